mips_mem_responder: RTL

MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

---
 rtl/mips_mem_responder.sv | 101 ++++++++++
 1 files changed

// File: rtl/mips_mem_responder.sv
// mips_mem_responder: word-addressed memory with wait states for a multicycle MIPS datapath.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   memread    read request, sampled only in IDLE
//   memwrite   write request, sampled only in IDLE
//   adr        byte address
//   writedata  store data
//   readdata   registered load/fetch data, held until the next valid read
//   memready   one-cycle completion strobe (high only in RESP)
//   memerr     error flag, meaningful only while memready is high
module mips_mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        memready,
  output logic        memerr
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   data_q;
  logic [31:0]   readdata_q;
  logic          wr_q;
  logic          err_q;
  logic          memready_q;
  logic          memerr_q;
  logic [31:0]   mem [DEPTH];
  logic          req;
  logic          in_err;
  logic [AW-1:0] in_idx;
  assign req    = memread | memwrite;
  assign in_err = (|adr[1:0]) | (|adr[31:AW+2]) | (memread & memwrite);
  assign in_idx = adr[AW+1:2];
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      data_q     <= 32'h0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      memready_q <= 1'b0;
      memerr_q   <= 1'b0;
      readdata_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          memready_q <= 1'b0;
          memerr_q   <= 1'b0;
          if (req) begin
            idx_q  <= in_idx;
            data_q <= writedata;
            wr_q   <= memwrite;
            err_q  <= in_err;
            if (WAIT_CYCLES > 0) begin
              state_q <= WAIT;
              cnt_q   <= 4'(WAIT_CYCLES - 1);
            end else begin
              // zero wait states: respond straight from the inputs being latched
              state_q    <= RESP;
              memready_q <= 1'b1;
              memerr_q   <= in_err;
              if (!memwrite && !in_err) readdata_q <= mem[in_idx];
            end
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
          else begin
            state_q    <= RESP;
            memready_q <= 1'b1;
            memerr_q   <= err_q;
            if (!wr_q && !err_q) readdata_q <= mem[idx_q];
          end
        end
        RESP: begin
          state_q    <= IDLE;
          memready_q <= 1'b0;
          memerr_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // storage is never reset; a reset during RESP suppresses the pending commit
  always_ff @(posedge clk)
    if (!reset && state_q == RESP && wr_q && !err_q) mem[idx_q] <= data_q;
  assign readdata = readdata_q;
  assign memready = memready_q;
  assign memerr   = memerr_q;
endmodule
